fifo_rd_stream: RTL and testbench

Read-side consumer for the dual-clock FIFO: drains the FIFO's read port (read enable, empty flag, data one cycle after the enable) and presents the words as a valid/ready stream in the read clock domain. It absorbs the RAM's one-cycle read latency with a 2-entry output buffer and credit-based read issue, so a continuously ready sink gets one word per cycle. The block sits between the FIFO read port and any single-clock consumer, such as a bus bridge or UART TX.

---
 rtl/fifo_rd_stream_pkg.sv | 7 +
 rtl/fifo_rd_stream.sv | 63 ++++++
 tb/tb_fifo_rd_stream.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_stream_pkg.sv
// rtl/fifo_rd_stream_pkg.sv - constants shared between the dual-clock FIFO and its read-side consumer
package fifo_rd_stream_pkg;

  // RAM read latency of the FIFO read port, in read-clock cycles.
  localparam int FIFO_RD_LAT = 1;

endpackage

// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - drains the FIFO read port into a valid/ready stream via a 2-entry skid buffer
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fifo_empty_i,
  output logic              fifo_renc_o,
  input  logic [DWIDTH-1:0] fifo_rdata_i,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [DWIDTH-1:0] m_data_o,
  output logic [1:0]        level_o
);

  // One slot per cycle of read latency plus the head, so a ready sink never starves.
  localparam logic [2:0] BUF_DEPTH = 3'(FIFO_RD_LAT + 1);

  logic [DWIDTH-1:0] r_slot0;
  logic [DWIDTH-1:0] r_slot1;
  logic [1:0]        r_count;
  logic              r_inflight;

  logic              w_pop;
  logic [2:0]        w_occ_next;
  logic [1:0]        w_count_post_pop;

  assign w_pop            = (r_count != 2'd0) & m_ready_i;
  assign w_count_post_pop = r_count - {1'b0, w_pop};
  assign w_occ_next       = {1'b0, r_count} + {2'b0, r_inflight} - {2'b0, w_pop};

  // Credit check counts the word already in flight so the buffer can never overflow.
  assign fifo_renc_o = ~fifo_empty_i & rst_n & (w_occ_next < BUF_DEPTH);

  assign m_valid_o = (r_count != 2'd0);
  assign m_data_o  = r_slot0;
  assign level_o   = r_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_slot0    <= '0;
      r_slot1    <= '0;
      r_count    <= 2'd0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= fifo_renc_o;
      r_count    <= w_occ_next[1:0];
      if (w_pop && (r_count == 2'd2)) begin
        r_slot0 <= r_slot1;
      end
      if (r_inflight) begin
        if (w_count_post_pop == 2'd0) begin
          r_slot0 <= fifo_rdata_i;
        end else begin
          r_slot1 <= fifo_rdata_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb/tb_fifo_rd_stream.sv - scoreboard bench for fifo_rd_stream with a behavioural FIFO read port
module tb_fifo_rd_stream;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       fifo_empty_i = 1'b1;
  logic       fifo_renc_o;
  logic [7:0] fifo_rdata_i = 8'h00;
  logic       m_valid_o;
  logic       m_ready_i = 1'b0;
  logic [7:0] m_data_o;
  logic [1:0] level_o;

  fifo_rd_stream #(.DWIDTH(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fifo_empty_i (fifo_empty_i),
    .fifo_renc_o  (fifo_renc_o),
    .fifo_rdata_i (fifo_rdata_i),
    .m_valid_o    (m_valid_o),
    .m_ready_i    (m_ready_i),
    .m_data_o     (m_data_o),
    .level_o      (level_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] src_q[$];
  logic [7:0] exp_q[$];
  logic       rst_v = 1'b0;
  logic       ready_v = 1'b1;
  logic       hold_empty_v = 1'b0;
  logic       have_next = 1'b0;
  logic [7:0] next_word = 8'h00;
  logic       inflight_tb = 1'b0;
  logic       last_renc, last_valid, last_pop;
  logic [7:0] last_data;
  logic [1:0] last_level;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // One read-clock cycle: drive after the edge, sample and score at the falling edge.
  task automatic cycle();
    @(posedge clk);
    #1;
    rst_n        = rst_v;
    fifo_rdata_i = have_next ? next_word : 8'hEE;
    have_next    = 1'b0;
    m_ready_i    = ready_v;
    fifo_empty_i = hold_empty_v || (src_q.size() == 0);
    @(negedge clk);
    last_renc  = fifo_renc_o;
    last_valid = m_valid_o;
    last_data  = m_data_o;
    last_level = level_o;
    last_pop   = 1'b0;
    if (fifo_empty_i) check_eq("renc_while_empty", 32'(fifo_renc_o), 0);
    if (!rst_n) begin
      check_eq("renc_in_reset", 32'(fifo_renc_o), 0);
      exp_q.delete();
      inflight_tb = 1'b0;
    end else begin
      check_eq("occupancy_le_2", 32'((32'(level_o) + 32'(inflight_tb)) <= 2), 1);
      if (m_valid_o && m_ready_i) begin
        last_pop = 1'b1;
        if (exp_q.size() == 0) check_eq("spurious_word", 32'(exp_q.size()), 1);
        else check_eq("data", 32'(m_data_o), 32'(exp_q.pop_front()));
      end
      if (fifo_renc_o) begin
        next_word = src_q.pop_front();
        have_next = 1'b1;
        exp_q.push_back(next_word);
      end
      inflight_tb = fifo_renc_o;
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || src_q.size() != 0) && n < budget) begin
      cycle();
      n++;
    end
    check_eq("drain_done", 32'(exp_q.size() + src_q.size()), 0);
  endtask

  initial begin
    int renc_first, renc_last, renc_cnt, val_first, val_last, val_cnt, gaps;
    logic [7:0] lost_word;

    // Reset held with a non-empty FIFO
    src_q.push_back(8'h5A);
    rst_v = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_eq("rst_renc", 32'(last_renc), 0);
      check_eq("rst_valid", 32'(last_valid), 0);
      check_eq("rst_level", 32'(last_level), 0);
    end
    rst_v = 1'b1;
    cycle();
    check_eq("first_renc_after_rst", 32'(last_renc), 1);
    drain(20);

    // Single word latency
    src_q.push_back(8'hA5);
    renc_first = -1; val_first = -1; val_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (last_renc && renc_first < 0) renc_first = i;
      if (last_valid) begin
        val_cnt++;
        if (val_first < 0) val_first = i;
        check_eq("single_data", 32'(last_data), 32'h A5);
      end
    end
    check_eq("single_valid_cycles", 32'(val_cnt), 1);
    check_eq("single_latency", 32'(val_first - renc_first), 2);

    // Streaming 16 words
    for (int w = 0; w < 16; w++) src_q.push_back(8'(w));
    renc_first = -1; renc_last = -1; renc_cnt = 0;
    val_first = -1; val_last = -1; val_cnt = 0;
    for (int i = 0; i < 24; i++) begin
      cycle();
      if (last_renc) begin
        renc_cnt++;
        if (renc_first < 0) renc_first = i;
        renc_last = i;
      end
      if (last_pop) begin
        val_cnt++;
        if (val_first < 0) val_first = i;
        val_last = i;
      end
    end
    check_eq("stream_renc_count", 32'(renc_cnt), 16);
    check_eq("stream_renc_span", 32'(renc_last - renc_first), 15);
    check_eq("stream_out_count", 32'(val_cnt), 16);
    check_eq("stream_out_span", 32'(val_last - val_first), 15);

    // Backpressure with sink stalled for 5 cycles
    for (int w = 0; w < 32; w++) src_q.push_back(8'(8'h10 + w));
    ready_v = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (i >= 3) begin
        check_eq("bp_level", 32'(last_level), 2);
        check_eq("bp_renc", 32'(last_renc), 0);
        check_eq("bp_hold_valid", 32'(last_valid), 1);
        check_eq("bp_hold_data", 32'(last_data), 32'h10);
      end
    end
    ready_v = 1'b1;
    cycle();
    check_eq("bp_release_renc", 32'(last_renc), 1);
    check_eq("bp_release_pop", 32'(last_pop), 1);
    gaps = 0;
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) begin
      cycle();
      if (!last_pop && exp_q.size() != 0) gaps++;
    end
    check_eq("bp_gaps", 32'(gaps), 0);
    drain(10);

    // Random ready / empty toggling
    for (int w = 0; w < 1000; w++) src_q.push_back(8'($urandom));
    for (int i = 0; i < 10000 && (exp_q.size() != 0 || src_q.size() != 0); i++) begin
      ready_v      = 1'($urandom_range(0, 1));
      hold_empty_v = ($urandom_range(0, 3) == 0);
      cycle();
    end
    ready_v      = 1'b1;
    hold_empty_v = 1'b0;
    drain(20);

    // Reset with a full buffer and a read in flight
    for (int w = 0; w < 8; w++) src_q.push_back(8'(8'h40 + w));
    ready_v = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    check_eq("mid_level_full", 32'(last_level), 2);
    ready_v = 1'b1;
    cycle();
    check_eq("mid_credit_renc", 32'(last_renc), 1);
    lost_word = next_word;
    ready_v = 1'b0;
    rst_v   = 1'b0;
    cycle();
    rst_v   = 1'b1;
    cycle();
    check_eq("mid_valid_after_rst", 32'(last_valid), 0);
    check_eq("mid_level_after_rst", 32'(last_level), 0);
    ready_v = 1'b1;
    for (int i = 0; i < 30 && (exp_q.size() != 0 || src_q.size() != 0); i++) begin
      cycle();
      if (last_pop && last_data == lost_word) check_eq("mid_lost_word_seen", 32'(last_data), 32'(~lost_word));
    end
    drain(10);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
